// File: rtl/pc_gen_redirect.sv
// rtl/pc_gen_redirect.sv - fetch PC generator with prioritised, stall-tolerant redirects and WFI halt
module pc_gen_redirect #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h8000_0000,
  parameter int              PC_STEP    = 4,
  parameter int              ALIGN_BITS = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_addr_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            halt_req_i,
  output logic            halted_o,
  output logic            redirect_o,
  output logic            misalign_o
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [1:0]      P_NONE     = 2'd0;
  localparam logic [1:0]      P_BRANCH   = 2'd1;
  localparam logic [1:0]      P_MRET     = 2'd2;
  localparam logic [1:0]      P_TRAP     = 2'd3;
  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

  state_t          state;
  logic            pend_vld;
  logic [1:0]      pend_prio;
  logic [XLEN-1:0] pend_addr;

  logic [1:0]      in_prio;
  logic [XLEN-1:0] in_addr;
  logic            use_pend;
  logic            eff_vld;
  logic [XLEN-1:0] eff_addr;
  logic            latch_in;
  logic            fire;

  always_comb begin
    in_prio = P_NONE;
    in_addr = branch_target_addr_i;
    if (trap_i) begin
      in_prio = P_TRAP;
      in_addr = trap_vector_i;
    end else if (mret_i) begin
      in_prio = P_MRET;
      in_addr = mepc_i;
    end else if (branch_taken_i) begin
      in_prio = P_BRANCH;
      in_addr = branch_target_addr_i;
    end
  end

  // The held request only beats a new one of strictly higher priority; ties go to the newer request.
  assign use_pend = pend_vld && (pend_prio > in_prio);
  assign eff_vld  = use_pend || (in_prio != P_NONE);
  assign eff_addr = use_pend ? pend_addr : in_addr;
  assign latch_in = (in_prio != P_NONE) && (!pend_vld || (in_prio >= pend_prio));

  assign valid_o  = (state == RUN) && !rst_i;
  assign fire     = valid_o && ready_i;
  assign halted_o = (state == HALT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RUN;
      pc_o       <= BOOT_ADDR;
      pend_vld   <= 1'b0;
      pend_prio  <= P_NONE;
      pend_addr  <= '0;
      redirect_o <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      redirect_o <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        RUN: begin
          if (fire) begin
            pend_vld <= 1'b0;
            if (eff_vld) begin
              pc_o       <= eff_addr & ALIGN_MASK;
              redirect_o <= 1'b1;
              misalign_o <= |(eff_addr & ~ALIGN_MASK);
            end else begin
              pc_o <= pc_o + STEP;
              if (halt_req_i) state <= HALT;
            end
          end else if (latch_in) begin
            pend_vld  <= 1'b1;
            pend_prio <= in_prio;
            pend_addr <= in_addr;
          end
        end
        HALT: begin
          // trap always wins arbitration, so eff_addr is the trap vector here
          if (trap_i) begin
            state      <= RUN;
            pc_o       <= eff_addr & ALIGN_MASK;
            redirect_o <= 1'b1;
            misalign_o <= |(eff_addr & ~ALIGN_MASK);
            pend_vld   <= 1'b0;
          end else if (latch_in) begin
            pend_vld  <= 1'b1;
            pend_prio <= in_prio;
            pend_addr <= in_addr;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen_redirect.sv
// tb/tb_pc_gen_redirect.sv - directed bench with a per-cycle behavioural model of pc_gen_redirect
module tb_pc_gen_redirect;

  localparam logic [31:0] BOOT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        valid;
  logic [31:0] pc;
  logic        br = 1'b0;
  logic [31:0] br_addr = '0;
  logic        mret = 1'b0;
  logic [31:0] mepc = '0;
  logic        trap = 1'b0;
  logic [31:0] tvec = '0;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        redirect;
  logic        misalign;

  int n_chk = 0;
  int n_fail = 0;

  pc_gen_redirect dut (
    .clk_i(clk), .rst_i(rst), .ready_i(ready), .valid_o(valid), .pc_o(pc),
    .branch_taken_i(br), .branch_target_addr_i(br_addr),
    .mret_i(mret), .mepc_i(mepc), .trap_i(trap), .trap_vector_i(tvec),
    .halt_req_i(halt_req), .halted_o(halted), .redirect_o(redirect), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: architectural view only - current pc, halted flag, one held request.
  logic        m_live = 1'b0;
  logic [31:0] m_pc;
  logic        m_halt, m_redir, m_mis;
  logic        m_pv;
  int          m_pp;
  logic [31:0] m_pa;

  task automatic m_take(input logic [31:0] a);
    m_pc    = a - (a % 4);
    m_redir = 1'b1;
    m_mis   = (a % 4) != 0;
  endtask

  always @(posedge clk) begin
    int          ip;
    logic [31:0] ia;
    if (rst) begin
      m_live = 1'b1; m_pc = BOOT; m_halt = 1'b0; m_pv = 1'b0; m_pp = 0;
      m_redir = 1'b0; m_mis = 1'b0;
    end else if (m_live) begin
      m_redir = 1'b0; m_mis = 1'b0;
      ip = trap ? 3 : mret ? 2 : br ? 1 : 0;
      ia = trap ? tvec : mret ? mepc : br_addr;
      if (m_halt) begin
        if (trap) begin
          m_take(tvec); m_halt = 1'b0; m_pv = 1'b0;
        end else if (ip > 0 && (!m_pv || ip >= m_pp)) begin
          m_pv = 1'b1; m_pp = ip; m_pa = ia;
        end
      end else if (ready) begin
        if (m_pv && m_pp > ip) m_take(m_pa);
        else if (ip > 0) m_take(ia);
        else begin
          m_pc = m_pc + 32'd4;
          if (halt_req) m_halt = 1'b1;
        end
        m_pv = 1'b0;
      end else if (ip > 0 && (!m_pv || ip >= m_pp)) begin
        m_pv = 1'b1; m_pp = ip; m_pa = ia;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model.valid", {31'd0, valid}, {31'd0, !m_halt && !rst});
      chk("model.pc", pc, m_pc);
      chk("model.halted", {31'd0, halted}, {31'd0, m_halt});
      chk("model.redirect", {31'd0, redirect}, {31'd0, m_redir});
      chk("model.misalign", {31'd0, misalign}, {31'd0, m_mis});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1 reset and sequential fetch
    step(); chk("t1.valid_in_rst", {31'd0, valid}, 32'd0);
    step(); chk("t1.pc_rst", pc, BOOT);
    chk("t1.valid_in_rst2", {31'd0, valid}, 32'd0);
    rst = 1'b0; #1;
    chk("t1.valid_after", {31'd0, valid}, 32'd1);
    ready = 1'b1;
    step(); chk("t1.pc4", pc, 32'h8000_0004);
    step(); chk("t1.pc8", pc, 32'h8000_0008);
    // T2 branch arriving during a stall is kept
    ready = 1'b0; br = 1'b1; br_addr = 32'hAAAA_BBB8;
    step(); chk("t2.hold", pc, 32'h8000_0008);
    br = 1'b0;
    step(); chk("t2.hold2", pc, 32'h8000_0008);
    chk("t2.valid_stall", {31'd0, valid}, 32'd1);
    ready = 1'b1;
    step(); chk("t2.redir_pc", pc, 32'hAAAA_BBB8);
    chk("t2.redir_pulse", {31'd0, redirect}, 32'd1);
    ready = 1'b0;
    step(); chk("t2.pulse_end", {31'd0, redirect}, 32'd0);
    // T3 priority, same cycle and across a stall
    ready = 1'b1; br = 1'b1; br_addr = 32'h9000_0000;
    mret = 1'b1; mepc = 32'h8000_1000; trap = 1'b1; tvec = 32'h8000_0100;
    step(); chk("t3.trap_wins", pc, 32'h8000_0100);
    br = 1'b0; mret = 1'b0; trap = 1'b0; ready = 1'b0;
    mret = 1'b1;
    step(); mret = 1'b0; br = 1'b1;
    step(); br = 1'b0; ready = 1'b1;
    step(); chk("t3.pend_mret", pc, 32'h8000_1000);
    // equal priority while stalled: newer branch replaces the older one
    ready = 1'b0; br = 1'b1; br_addr = 32'h1111_0000;
    step(); br_addr = 32'h2222_0000;
    step(); br = 1'b0; ready = 1'b1;
    step(); chk("t3.newer_wins", pc, 32'h2222_0000);
    // T4 misaligned target
    br = 1'b1; br_addr = 32'h9000_0006;
    step(); chk("t4.aligned", pc, 32'h9000_0004);
    chk("t4.misalign", {31'd0, misalign}, 32'd1);
    br = 1'b0; ready = 1'b0;
    step(); chk("t4.misalign_end", {31'd0, misalign}, 32'd0);
    // T5 WFI halt and trap wake
    ready = 1'b1; halt_req = 1'b1;
    step(); chk("t5.halted", {31'd0, halted}, 32'd1);
    chk("t5.valid0", {31'd0, valid}, 32'd0);
    chk("t5.resume_pc", pc, 32'h9000_0008);
    halt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ready = ~ready;
      if (i == 1) begin br = 1'b1; br_addr = 32'h5555_0000; end
      else br = 1'b0;
      step();
    end
    chk("t5.halt_hold", pc, 32'h9000_0008);
    trap = 1'b1; tvec = 32'h8000_0100;
    step(); chk("t5.wake_pc", pc, 32'h8000_0100);
    chk("t5.wake_valid", {31'd0, valid}, 32'd1);
    trap = 1'b0; ready = 1'b1;
    step(); chk("t5.pend_dropped", pc, 32'h8000_0104);
    // T6 wrap, then reset while halted with a branch held
    br = 1'b1; br_addr = 32'hFFFF_FFFC;
    step(); br = 1'b0;
    step(); chk("t6.wrap", pc, 32'h0000_0000);
    halt_req = 1'b1;
    step(); halt_req = 1'b0; chk("t6.halt", {31'd0, halted}, 32'd1);
    br = 1'b1; br_addr = 32'h1234_5670;
    step(); br = 1'b0; rst = 1'b1;
    step(); chk("t6.rst_pc", pc, BOOT);
    chk("t6.rst_run", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    step(); chk("t6.no_pend", pc, BOOT + 32'd4);
    chk("t6.no_redir", {31'd0, redirect}, 32'd0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
